latch_bank_wrctl: RTL and testbench

//  Write controller/arbiter for a bank of NLAT gated D latches (NAND-built, WIDTH bits each, enable CL-style).

---
 rtl/latch_bank_wrctl.sv | 182 ++++++++++++++++++
 tb/tb_latch_bank_wrctl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_wrctl.sv
// Write controller for a bank of gated D latches. Round-robin arbitration
// among requesters, then each write runs as SETUP -> PULSE -> HOLD so the
// latch data bus is stable whenever an enable is high. Every output comes
// straight from a flop, so the latch enables are glitch-free.
module latch_bank_wrctl #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int NLAT      = 8,
    parameter int AW        = 3,
    parameter int PULSE_CYC = 1
) (
    input  logic                  CL,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*AW-1:0]    WADDR,
    input  logic [NREQ*WIDTH-1:0] WDATA,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic                  ERR,
    output logic [WIDTH-1:0]      LD,
    output logic [NLAT-1:0]       LEN,
    output logic                  BUSY
);

    localparam int          IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NLAT_U     = NLAT;
    localparam logic [3:0]  PULSE_LAST = 4'(PULSE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     winner_q, winner_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [NLAT-1:0]   len_q, len_d;

    logic [AW-1:0]     waddr_arr [NREQ];
    logic [WIDTH-1:0]  wdata_arr [NREQ];
    logic [NLAT-1:0]   len_hit;
    logic              addr_ok;
    logic [NREQ-1:0]   req_eff;
    logic              found;
    logic [IW-1:0]     win;
    int                arb_idx;

    // Split the flat request buses into per-requester words.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign waddr_arr[gi] = WADDR[gi*AW +: AW];
            assign wdata_arr[gi] = WDATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // An address past the end of the bank enables nothing and reports ERR.
    assign addr_ok = (32'(addr_q) < NLAT_U);

    // One-hot enable pattern for the captured address.
    generate
        for (genvar gi = 0; gi < NLAT; gi++) begin : g_len
            assign len_hit[gi] = addr_ok && (addr_q == AW'(gi));
        end
    endgenerate

    // Round-robin search starting at the pointer; a requester being told
    // DONE this cycle is still showing its old REQ and must be skipped.
    always_comb begin
        req_eff = REQ & ~done_q;
        found   = 1'b0;
        win     = '0;
        arb_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = int'(rr_q) + k;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!found && req_eff[IW'(arb_idx)]) begin
                found = 1'b1;
                win   = IW'(arb_idx);
            end
        end
    end

    // Write sequencer next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        len_d    = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d      = ST_SETUP;
                    winner_d     = win;
                    addr_d       = waddr_arr[win];
                    data_d       = wdata_arr[win];
                    gnt_d        = '0;
                    gnt_d[win]   = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                len_d   = len_hit;
                cnt_d   = PULSE_LAST;
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    len_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d          = ST_IDLE;
                gnt_d            = '0;
                done_d[winner_q] = 1'b1;
                err_d            = ~addr_ok;
                busy_d           = 1'b0;
                rr_d             = (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + IW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset also kills any enable in flight.
    always_ff @(posedge CL) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            winner_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            len_q    <= len_d;
        end
    end

    assign GNT  = gnt_q;
    assign DONE = done_q;
    assign ERR  = err_q;
    assign LD   = data_q;
    assign LEN  = len_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_latch_bank_wrctl.sv
// Directed bench for latch_bank_wrctl. Instance A: 8 latches, 1-cycle pulse.
// Instance B: 6 latches, 3-cycle pulse. Each instance drives a behavioural
// latch-bank model so written contents can be checked.
`timescale 1ns/1ps
module tb_latch_bank_wrctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req_a = '0;
    logic [11:0] waddr_a = '0;
    logic [31:0] wdata_a = '0;
    logic [3:0]  gnt_a, done_a;
    logic        err_a, busy_a;
    logic [7:0]  ld_a;
    logic [7:0]  len_a;

    logic [3:0]  req_b = '0;
    logic [11:0] waddr_b = '0;
    logic [31:0] wdata_b = '0;
    logic [3:0]  gnt_b, done_b;
    logic        err_b, busy_b;
    logic [7:0]  ld_b;
    logic [5:0]  len_b;

    logic [7:0]  latch_a [8];
    logic [7:0]  latch_b [6];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit sim_done = 1'b0;

    always #5 clk = ~clk;

    latch_bank_wrctl #(.NREQ(4), .WIDTH(8), .NLAT(8), .AW(3), .PULSE_CYC(1)) u_a (
        .CL(clk), .RST(rst), .REQ(req_a), .WADDR(waddr_a), .WDATA(wdata_a),
        .GNT(gnt_a), .DONE(done_a), .ERR(err_a), .LD(ld_a), .LEN(len_a), .BUSY(busy_a)
    );

    latch_bank_wrctl #(.NREQ(4), .WIDTH(8), .NLAT(6), .AW(3), .PULSE_CYC(3)) u_b (
        .CL(clk), .RST(rst), .REQ(req_b), .WADDR(waddr_b), .WDATA(wdata_b),
        .GNT(gnt_b), .DONE(done_b), .ERR(err_b), .LD(ld_b), .LEN(len_b), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, settle, then apply the latch model (transparent while enabled).
    task automatic tick();
        @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) if (len_a[j]) latch_a[j] = ld_a;
        for (int j = 0; j < 6; j++) if (len_b[j]) latch_b[j] = ld_b;
    endtask

    initial begin
        repeat (2000) @(posedge clk);
        if (!sim_done) begin
            n_chk++;
            n_fail++;
            $error("FAIL timeout: stimulus did not finish within 2000 cycles");
            $finish;
        end
    end

    initial begin
        for (int j = 0; j < 8; j++) latch_a[j] = 8'h00;
        for (int j = 0; j < 6; j++) latch_b[j] = 8'h00;

        // 1. Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_gnt",  gnt_a,  4'h0);
        chk("rst_done", done_a, 4'h0);
        chk("rst_len",  len_a,  8'h00);
        chk("rst_ld",   ld_a,   8'h00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_err",  err_a,  1'b0);
        chk("rst_len_b", len_b, 6'h00);
        chk("rst_busy_b", busy_b, 1'b0);
        $display("txn reset: gnt=%h len=%h ld=%h busy=%b", gnt_a, len_a, ld_a, busy_a);

        // 2. Single write by requester 2 to latch 5
        waddr_a[2*3 +: 3] = 3'd5;
        wdata_a[2*8 +: 8] = 8'hA5;
        req_a = 4'b0100;
        tick();
        chk("w2_setup_gnt",  gnt_a,  4'b0100);
        chk("w2_setup_ld",   ld_a,   8'hA5);
        chk("w2_setup_len",  len_a,  8'h00);
        chk("w2_setup_busy", busy_a, 1'b1);
        tick();
        chk("w2_pulse_len",  len_a,  8'b0010_0000);
        chk("w2_pulse_ld",   ld_a,   8'hA5);
        tick();
        chk("w2_hold_len",   len_a,  8'h00);
        chk("w2_hold_ld",    ld_a,   8'hA5);
        chk("w2_hold_done",  done_a, 4'h0);
        tick();
        chk("w2_done",       done_a, 4'b0100);
        chk("w2_done_gnt",   gnt_a,  4'h0);
        chk("w2_done_err",   err_a,  1'b0);
        chk("w2_latch5",     latch_a[5], 8'hA5);
        tick();
        chk("w2_no_regrant", gnt_a,  4'h0);
        chk("w2_idle_busy",  busy_a, 1'b0);
        chk("w2_ld_holds",   ld_a,   8'hA5);
        req_a = 4'b0000;
        $display("txn single write: req2 addr5 data a5 latch5=%h", latch_a[5]);

        // 3. All requesters high from reset: grants 0,1,2,3,0
        for (int r = 0; r < 4; r++) begin
            waddr_a[r*3 +: 3] = 3'(r);
            wdata_a[r*8 +: 8] = 8'(8'h11 * (r + 1));
        end
        rst = 1'b1;
        req_a = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            int w;
            w = i % 4;
            chk("rr_gnt",  gnt_a, 4'h1 << w);
            tick();
            chk("rr_len",  len_a, 8'h01 << w);
            tick();
            tick();
            chk("rr_done", done_a, 4'h1 << w);
            $display("txn rr grant %0d: requester %0d done=%h", i, w, done_a);
            if (i == 4) req_a = 4'b0000;
            tick();
        end
        chk("rr_idle_busy", busy_a, 1'b0);
        chk("rr_latch0", latch_a[0], 8'h11);
        chk("rr_latch1", latch_a[1], 8'h22);
        chk("rr_latch2", latch_a[2], 8'h33);
        chk("rr_latch3", latch_a[3], 8'h44);

        // 4. Out-of-range address on the 6-latch instance
        waddr_b[1*3 +: 3] = 3'd7;
        wdata_b[1*8 +: 8] = 8'h77;
        req_b = 4'b0010;
        tick();
        chk("oob_gnt", gnt_b, 4'b0010);
        for (int p = 0; p < 3; p++) begin
            tick();
            chk("oob_pulse_len", len_b, 6'h00);
        end
        tick();
        chk("oob_hold_len", len_b, 6'h00);
        chk("oob_hold_err", err_b, 1'b0);
        tick();
        chk("oob_done", done_b, 4'b0010);
        chk("oob_err",  err_b,  1'b1);
        chk("oob_latches", {latch_b[5], latch_b[4], latch_b[3], latch_b[2], latch_b[1], latch_b[0]}, 48'h0);
        req_b = 4'b0000;
        tick();
        chk("oob_err_clear", err_b, 1'b0);
        $display("txn out-of-range: req1 addr7 err pulsed, latches untouched");

        // 5. Reset during PULSE, then the held request restarts
        waddr_a[1*3 +: 3] = 3'd4;
        wdata_a[1*8 +: 8] = 8'h5A;
        req_a = 4'b0010;
        tick();
        chk("abort_setup_gnt", gnt_a, 4'b0010);
        tick();
        chk("abort_pulse_len", len_a, 8'h10);
        rst = 1'b1;
        tick();
        chk("abort_len",  len_a,  8'h00);
        chk("abort_gnt",  gnt_a,  4'h0);
        chk("abort_busy", busy_a, 1'b0);
        rst = 1'b0;
        tick();
        chk("abort_no_done", done_a, 4'h0);
        chk("restart_gnt",   gnt_a,  4'b0010);
        tick();
        chk("restart_len",   len_a,  8'h10);
        tick();
        tick();
        chk("restart_done",  done_a, 4'b0010);
        chk("restart_latch4", latch_a[4], 8'h5A);
        req_a = 4'b0000;
        $display("txn reset abort: requester 1 restarted, latch4=%h", latch_a[4]);

        // 6. Three-cycle pulse, WDATA/WADDR change after the snapshot
        waddr_b[0*3 +: 3] = 3'd2;
        wdata_b[0*8 +: 8] = 8'hC3;
        req_b = 4'b0001;
        tick();
        chk("p3_setup_ld", ld_b, 8'hC3);
        wdata_b[0*8 +: 8] = 8'h3C;
        waddr_b[0*3 +: 3] = 3'd5;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk("p3_pulse_len", len_b, 6'b000100);
            chk("p3_pulse_ld",  ld_b,  8'hC3);
        end
        tick();
        chk("p3_hold_len", len_b, 6'h00);
        chk("p3_hold_ld",  ld_b,  8'hC3);
        tick();
        chk("p3_done",     done_b, 4'b0001);
        chk("p3_err",      err_b,  1'b0);
        chk("p3_latch2",   latch_b[2], 8'hC3);
        chk("p3_latch5",   latch_b[5], 8'h00);
        req_b = 4'b0000;
        $display("txn pulse3: req0 addr2 latch2=%h", latch_b[2]);

        sim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
